// File: rtl/ace_ccu_snoop_arb_pkg.sv
// Default ACE snoop channel types for ace_ccu_snoop_arb.
// Integrators normally override these with their own snoop structs.
package ace_ccu_snoop_arb_pkg;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] snoop;
        logic [2:0] prot;
    } ace_ac_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } ace_cd_chan_t;

    typedef logic [4:0] ace_cr_resp_t;

    typedef struct packed {
        logic         ac_valid;
        ace_ac_chan_t ac;
        logic         cr_ready;
        logic         cd_ready;
    } ace_snoop_req_t;

    typedef struct packed {
        logic         ac_ready;
        logic         cr_valid;
        ace_cr_resp_t cr_resp;
        logic         cd_valid;
        ace_cd_chan_t cd;
    } ace_snoop_resp_t;

endpackage

// File: rtl/ace_ccu_snoop_arb.sv
// N-to-1 ACE snoop arbiter: round-robin AC grant with lock-until-handshake,
// in-order CR/CD return routing through two index FIFOs, bounded in-flight count.
module ace_ccu_snoop_arb #(
    parameter int unsigned NoSnoopPorts   = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type snoop_req_t   = ace_ccu_snoop_arb_pkg::ace_snoop_req_t,
    parameter type snoop_resp_t  = ace_ccu_snoop_arb_pkg::ace_snoop_resp_t,
    parameter type domain_mask_t = logic,
    localparam int unsigned IdxW = (NoSnoopPorts > 1) ? $clog2(NoSnoopPorts) : 1,
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  snoop_req_t   [NoSnoopPorts-1:0] slv_snoop_reqs_i,
    output snoop_resp_t  [NoSnoopPorts-1:0] slv_snoop_resps_o,
    input  domain_mask_t [NoSnoopPorts-1:0] slv_masks_i,
    output snoop_req_t                      mst_snoop_req_o,
    input  snoop_resp_t                     mst_snoop_resp_i,
    output domain_mask_t                    mst_mask_o,
    output logic [CntW-1:0]                 outstanding_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
        return (i == IdxW'(NoSnoopPorts - 1)) ? '0 : i + 1'b1;
    endfunction

    logic [IdxW-1:0] rr_q, lock_idx_q, cand_idx, scan_idx;
    logic            lock_q;
    logic            cand_valid, mst_ac_valid, ac_hs;
    logic            cr_ready_m, cr_hs, cd_push;
    logic            cd_ready_m, cd_last_hs;

    logic [IdxW-1:0] cr_mem [MaxOutstanding];
    logic [IdxW-1:0] cd_mem [MaxOutstanding];
    logic [PtrW-1:0] cr_wr_q, cr_rd_q, cd_wr_q, cd_rd_q;
    logic [CntW-1:0] cr_cnt_q, cd_cnt_q;
    logic            cr_empty, cd_empty, cd_full;
    logic [IdxW-1:0] cr_head, cd_head;

    assign cr_empty      = (cr_cnt_q == '0);
    assign cd_empty      = (cd_cnt_q == '0);
    assign cd_full       = (cd_cnt_q == CntW'(MaxOutstanding));
    assign cr_head       = cr_mem[cr_rd_q];
    assign cd_head       = cd_mem[cd_rd_q];
    assign outstanding_o = cr_cnt_q + cd_cnt_q;

    // Scan downward so the port closest to rr_q is the last (winning) assignment.
    always_comb begin
        cand_idx = lock_idx_q;
        scan_idx = rr_q;
        if (!lock_q) begin
            cand_idx = rr_q;
            for (int i = int'(NoSnoopPorts) - 1; i >= 0; i--) begin
                scan_idx = IdxW'((int'(rr_q) + i) % NoSnoopPorts);
                if (slv_snoop_reqs_i[scan_idx].ac_valid) cand_idx = scan_idx;
            end
        end
    end

    assign cand_valid   = slv_snoop_reqs_i[cand_idx].ac_valid;
    assign mst_ac_valid = cand_valid && (outstanding_o < CntW'(MaxOutstanding));
    assign ac_hs        = mst_ac_valid && mst_snoop_resp_i.ac_ready;

    // A data-carrying CR needs a free CD slot before it may complete.
    assign cr_ready_m = !cr_empty && slv_snoop_reqs_i[cr_head].cr_ready
                        && !(mst_snoop_resp_i.cr_resp[0] && cd_full);
    assign cr_hs      = mst_snoop_resp_i.cr_valid && cr_ready_m;
    assign cd_push    = cr_hs && mst_snoop_resp_i.cr_resp[0];
    assign cd_ready_m = !cd_empty && slv_snoop_reqs_i[cd_head].cd_ready;
    assign cd_last_hs = mst_snoop_resp_i.cd_valid && cd_ready_m && mst_snoop_resp_i.cd.last;

    always_comb begin
        mst_snoop_req_o          = '0;
        slv_snoop_resps_o        = '0;
        mst_mask_o               = slv_masks_i[cand_idx];
        mst_snoop_req_o.ac_valid = mst_ac_valid;
        mst_snoop_req_o.ac       = slv_snoop_reqs_i[cand_idx].ac;
        mst_snoop_req_o.cr_ready = cr_ready_m;
        mst_snoop_req_o.cd_ready = cd_ready_m;
        slv_snoop_resps_o[cand_idx].ac_ready = ac_hs;
        if (!cr_empty) begin
            slv_snoop_resps_o[cr_head].cr_valid = mst_snoop_resp_i.cr_valid;
            slv_snoop_resps_o[cr_head].cr_resp  = mst_snoop_resp_i.cr_resp;
        end
        if (!cd_empty) begin
            slv_snoop_resps_o[cd_head].cd_valid = mst_snoop_resp_i.cd_valid;
            slv_snoop_resps_o[cd_head].cd       = mst_snoop_resp_i.cd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cr_wr_q    <= '0;
            cr_rd_q    <= '0;
            cd_wr_q    <= '0;
            cd_rd_q    <= '0;
            cr_cnt_q   <= '0;
            cd_cnt_q   <= '0;
        end else begin
            if (ac_hs) begin
                lock_q <= 1'b0;
                rr_q   <= idx_inc(cand_idx);
            end else if (mst_ac_valid) begin
                lock_q     <= 1'b1;
                lock_idx_q <= cand_idx;
            end
            if (ac_hs)      cr_wr_q <= ptr_inc(cr_wr_q);
            if (cr_hs)      cr_rd_q <= ptr_inc(cr_rd_q);
            if (cd_push)    cd_wr_q <= ptr_inc(cd_wr_q);
            if (cd_last_hs) cd_rd_q <= ptr_inc(cd_rd_q);
            cr_cnt_q <= cr_cnt_q + CntW'(ac_hs) - CntW'(cr_hs);
            cd_cnt_q <= cd_cnt_q + CntW'(cd_push) - CntW'(cd_last_hs);
        end
    end

    // Route storage holds data only; occupancy is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (ac_hs)   cr_mem[cr_wr_q] <= cand_idx;
        if (cd_push) cd_mem[cd_wr_q] <= cr_head;
    end

endmodule
